// File: rtl/map_table_ckpt.sv
// rtl/map_table_ckpt.sv - two-lane rename map table with ROB-walk and checkpoint recovery
module map_table_ckpt #(
    parameter int LREGS = 32,
    parameter int PREGS = 64,
    parameter int CKPTS = 4,
    localparam int LW = $clog2(LREGS),
    localparam int PW = $clog2(PREGS),
    localparam int CW = (CKPTS > 1) ? $clog2(CKPTS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] l_rs0,
    input  logic [LW-1:0] l_rt0,
    input  logic [LW-1:0] l_rd0,
    input  logic [LW-1:0] l_rs1,
    input  logic [LW-1:0] l_rt1,
    input  logic [LW-1:0] l_rd1,
    input  logic [PW-1:0] p_rd_new0,
    input  logic [PW-1:0] p_rd_new1,
    input  logic          RegDest0,
    input  logic          RegDest1,
    input  logic          hazard_stall,
    input  logic          recover,
    input  logic [LW-1:0] recover_rd,
    input  logic [PW-1:0] p_rd_flush,
    input  logic          RegDest_ROB,
    input  logic [PW-1:0] p_rd_compl,
    input  logic          complete,
    input  logic          RegDest_compl,
    input  logic          ckpt_take,
    input  logic [CW-1:0] ckpt_take_id,
    input  logic          ckpt_restore,
    input  logic [CW-1:0] ckpt_restore_id,
    output logic [PW-1:0] p_rs0,
    output logic [PW-1:0] p_rt0,
    output logic [PW-1:0] p_rs1,
    output logic [PW-1:0] p_rt1,
    output logic          p_rs0_v,
    output logic          p_rt0_v,
    output logic          p_rs1_v,
    output logic          p_rt1_v,
    output logic [PW-1:0] PR_old_rd0,
    output logic [PW-1:0] PR_old_rd1
);

    logic [PW-1:0] map_q   [LREGS];
    logic [PW-1:0] map_l0  [LREGS];
    logic [PW-1:0] map_nxt [LREGS];
    logic [PW-1:0] ckpt_q  [CKPTS][LREGS];
    logic [PREGS-1:0] ready_q;

    logic disp_en, take_en, restore_ok, cdb_hit;
    logic byp_rs1, byp_rt1;

    assign disp_en    = !hazard_stall && !recover && !ckpt_restore;
    assign take_en    = disp_en && ckpt_take && (int'(ckpt_take_id) < CKPTS);
    assign restore_ok = int'(ckpt_restore_id) < CKPTS;
    assign cdb_hit    = complete && RegDest_compl;

    // Lane 1 sees lane 0's destination as if it had already been renamed.
    assign byp_rs1 = RegDest0 && (l_rd0 == l_rs1);
    assign byp_rt1 = RegDest0 && (l_rd0 == l_rt1);

    assign p_rs0      = map_q[l_rs0];
    assign p_rt0      = map_q[l_rt0];
    assign p_rs1      = byp_rs1 ? p_rd_new0 : map_q[l_rs1];
    assign p_rt1      = byp_rt1 ? p_rd_new0 : map_q[l_rt1];
    assign PR_old_rd0 = map_q[l_rd0];
    assign PR_old_rd1 = (RegDest0 && (l_rd0 == l_rd1)) ? p_rd_new0 : map_q[l_rd1];

    assign p_rs0_v = ready_q[p_rs0] || (cdb_hit && (p_rs0 == p_rd_compl));
    assign p_rt0_v = ready_q[p_rt0] || (cdb_hit && (p_rt0 == p_rd_compl));
    assign p_rs1_v = !byp_rs1 && (ready_q[p_rs1] || (cdb_hit && (p_rs1 == p_rd_compl)));
    assign p_rt1_v = !byp_rt1 && (ready_q[p_rt1] || (cdb_hit && (p_rt1 == p_rd_compl)));

    // map_l0 is the intermediate image a lane-0 branch checkpoints.
    always_comb begin
        map_l0 = map_q;
        if (disp_en && RegDest0) begin
            map_l0[l_rd0] = p_rd_new0;
        end
        map_nxt = map_l0;
        if (disp_en && RegDest1) begin
            map_nxt[l_rd1] = p_rd_new1;
        end
        if (ckpt_restore) begin
            if (restore_ok) begin
                for (int j = 0; j < LREGS; j++) begin
                    map_nxt[j] = ckpt_q[ckpt_restore_id][j];
                end
            end
        end else if (recover && RegDest_ROB) begin
            map_nxt[recover_rd] = p_rd_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LREGS; i++) begin
                map_q[i] <= PW'(i);
            end
        end else begin
            map_q <= map_nxt;
        end
    end

    // Later assignments win, so a same-cycle allocation overrides completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PREGS; i++) begin
                ready_q[i] <= (i < LREGS);
            end
        end else begin
            if (cdb_hit) begin
                ready_q[p_rd_compl] <= 1'b1;
            end
            if (disp_en && RegDest0) begin
                ready_q[p_rd_new0] <= 1'b0;
            end
            if (disp_en && RegDest1) begin
                ready_q[p_rd_new1] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && take_en) begin
            for (int j = 0; j < LREGS; j++) begin
                ckpt_q[ckpt_take_id][j] <= map_l0[j];
            end
        end
    end

endmodule

// File: doc/map_table_ckpt.md
# map_table_ckpt

Parametrised two-lane rename map table for the OoO pipeline, successor to the single-lane map table. Translates two logical source pairs per cycle to physical tags with ready bits, allocates two destinations per cycle with intra-group bypass, and tracks completion. Recovery works two ways: a ROB-walk restore of one entry per cycle, and a single-cycle restore from branch checkpoints. Sits in the dispatch stage between decode/free-list and the reservation stations/ROB.

## Interface
- LREGS, 32: logical register count; LW = clog2(LREGS)
- PREGS, 64: physical register count; PW = clog2(PREGS)
- CKPTS, 4: checkpoint slots; CW = clog2(CKPTS), minimum 1
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- l_rs0, l_rt0, l_rd0, l_rs1, l_rt1, l_rd1  in  LW each  lane 0/1 logical sources/dest
- p_rd_new0, p_rd_new1  in  PW  free-list tags for lane 0/1 dest
- RegDest0, RegDest1  in  1  lane writes a destination
- hazard_stall  in  1  block all dispatch writes and checkpoint takes
- recover  in  1  ROB-walk recovery active
- recover_rd  in  LW, p_rd_flush  in  PW, RegDest_ROB  in  1  walk-back entry
- p_rd_compl  in  PW, complete  in  1, RegDest_compl  in  1  CDB completion
- ckpt_take  in  1, ckpt_take_id  in  CW  snapshot request (branch in lane 0)
- ckpt_restore  in  1, ckpt_restore_id  in  CW  mispredict restore
- p_rs0, p_rt0, p_rs1, p_rt1  out  PW  physical source tags
- p_rs0_v, p_rt0_v, p_rs1_v, p_rt1_v  out  1  source ready
- PR_old_rd0, PR_old_rd1  out  PW  previous mapping of l_rdN (goes to the ROB)

## Operation
- State: map[LREGS] of PW bits, ready[PREGS], ckpt[CKPTS][LREGS].
- Reset (rst=0 at posedge): map[i]=i; ready[i]=1 for i<LREGS, 0 otherwise; checkpoint contents are don't-care. Outputs follow combinationally from the reset state.
- Lookups are combinational from the current map.
  - Lane 1 bypass: if RegDest0 and l_rd0 matches l_rs1/l_rt1, the tag is p_rd_new0 and ready is 0. PR_old_rd1 = p_rd_new0 when RegDest0 and l_rd1==l_rd0.
  - Ready outputs are also forwarded from the CDB: ready=1 if the tag equals p_rd_compl and complete&RegDest_compl.
- Dispatch write, when !hazard_stall, !recover and !ckpt_restore:
  - RegDestN: map[l_rdN]<=p_rd_newN and ready[p_rd_newN]<=0.
  - Both lanes with the same l_rd: lane 1 wins.
- Complete: ready[p_rd_compl]<=1 when complete&RegDest_compl. This is applied in every mode, including recovery. If the same tag is allocated in the same cycle, the dispatch clear wins.
- ROB walk: when recover&RegDest_ROB, map[recover_rd]<=p_rd_flush. No dispatch writes while recover=1.
- Checkpoint take, when ckpt_take&!hazard_stall&!recover&!ckpt_restore:
  - ckpt[ckpt_take_id] <= the map after the lane 0 write and before the lane 1 write.
- Restore: when ckpt_restore, map<=ckpt[ckpt_restore_id] in one cycle. Ready bits are not restored.
- Priority: ckpt_restore > recover > dispatch/take. Completion is always applied.
- Out-of-range ids (CKPTS not a power of 2) are ignored.

## Timing
- Lookup outputs are combinational; zero latency from inputs.
- All map, ready and checkpoint updates take effect at the next posedge, visible to lookups in the following cycle.
- Restore: the map is fully restored one cycle after ckpt_restore is sampled. Dispatch resumes that cycle.
- Reset mid-recovery or mid-restore: reset dominates all other inputs.

## Test plan
- Reset then lane0 ADD r3,r1,r2 with new=0x20: p_rs0=0x01 and p_rt0=0x02, both ready; PR_old_rd0=0x03. Next cycle, lookup of r3 gives 0x20 with ready 0.
- Same cycle, lane0 writes r5 with new=0x21 and lane1 reads r5 and writes r5 with new=0x22:
  - p_rs1=0x21 with ready 0; PR_old_rd1=0x21.
  - Next cycle, map[5]=0x22.
- Completion of 0x20 with complete=1 and RegDest_compl=0: r3 stays not ready. With both set, the same-cycle lookup of r3 shows ready 1.
- Take ckpt 2 with lane0 writing r7 (new 0x23) and lane1 writing r8 (new 0x24); then write r7 with new 0x25; then restore ckpt 2:
  - Next cycle, r7 maps to 0x23 and r8 maps to 8.
- recover=1 with RegDest_ROB=1, recover_rd=6, p_rd_flush=0x06, and a lane0 write in the same cycle: map[6]=0x06 and the dispatch write is dropped.
- Same cycle: hazard_stall=1 with RegDest0, ckpt_take, and complete of 0x21:
  - Map and checkpoint are unchanged.
  - ready[0x21] is set.
